// File: rtl/clk_div_pkg.sv
// Shared defaults and helpers for the programmable clock divider.
package clk_div_pkg;

    localparam int DEFAULT_WIDTH       = 8;
    localparam int DEFAULT_DIV_RATIO   = 2;

    // High length of one output period: odd ratios stay high one cycle longer than low.
    function automatic logic [31:0] high_len(input logic [31:0] na);
        return (na + 32'd1) >> 1;
    endfunction

endpackage

// File: rtl/clk_div_ratio_ctrl.sv
// Ratio handshake: captures a requested ratio into a shadow register, holds it
// pending and swaps it into the active ratio at a safe point, pulsing load_ack.
module clk_div_ratio_ctrl
    import clk_div_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int DEFAULT_DIV = DEFAULT_DIV_RATIO
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             wrap,
    input  logic             load,
    input  logic [WIDTH-1:0] div_in,
    output logic [WIDTH-1:0] na,
    output logic [WIDTH-1:0] shadow,
    output logic             pending,
    output logic             apply,
    output logic             load_ack
);

    logic [WIDTH-1:0] na_q, na_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic             load_ack_q, load_ack_d;
    logic [WIDTH-1:0] div_clamped;

    // A zero request means "no division", i.e. ratio 1.
    assign div_clamped = (div_in == '0) ? WIDTH'(1) : div_in;

    // Running: swap only at a period boundary. Paused: swap right away, the counter
    // is parked so the next enabled edge starts a fresh period.
    assign apply = pending_q && (!en || wrap);

    // Next-state for the active ratio, shadow, pending flag and ack pulse.
    always_comb begin
        na_d       = na_q;
        shadow_d   = shadow_q;
        pending_d  = pending_q;
        load_ack_d = 1'b0;
        if (apply) begin
            na_d       = shadow_q;
            pending_d  = 1'b0;
            load_ack_d = 1'b1;
        end else if (load && !pending_q) begin
            shadow_d  = div_clamped;
            pending_d = 1'b1;
        end
    end

    // Handshake state registers; reset abandons any outstanding request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            na_q       <= WIDTH'(DEFAULT_DIV);
            shadow_q   <= WIDTH'(DEFAULT_DIV);
            pending_q  <= 1'b0;
            load_ack_q <= 1'b0;
        end else begin
            na_q       <= na_d;
            shadow_q   <= shadow_d;
            pending_q  <= pending_d;
            load_ack_q <= load_ack_d;
        end
    end

    assign na       = na_q;
    assign shadow   = shadow_q;
    assign pending  = pending_q;
    assign load_ack = load_ack_q;

endmodule

// File: rtl/clk_div_prog.sv
// Programmable integer clock divider with glitch-free ratio changes.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int DEFAULT_DIV = DEFAULT_DIV_RATIO
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] div_in,
    input  logic             load,
    output logic             load_ack,
    output logic             pending,
    output logic             clk_out,
    output logic             tick
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic [WIDTH-1:0] na;
    logic [WIDTH-1:0] shadow;
    logic             apply;
    logic             wrap;
    logic [WIDTH-1:0] cnt_inc;
    logic [31:0]      high;

    clk_div_ratio_ctrl #(
        .WIDTH       (WIDTH),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ratio_ctrl (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .wrap     (wrap),
        .load     (load),
        .div_in   (div_in),
        .na       (na),
        .shadow   (shadow),
        .pending  (pending),
        .apply    (apply),
        .load_ack (load_ack)
    );

    assign wrap    = (cnt_q == na - WIDTH'(1));
    assign cnt_inc = wrap ? '0 : cnt_q + WIDTH'(1);
    assign high    = high_len(32'(na));

    // Counter and output next-state; a paused divider holds its phase.
    always_comb begin
        cnt_d     = cnt_q;
        clk_out_d = clk_out_q;
        tick_d    = 1'b0;
        if (en) begin
            if (apply) begin
                cnt_d     = '0;
                clk_out_d = 1'b1;
                tick_d    = 1'b1;
            end else begin
                cnt_d     = cnt_inc;
                clk_out_d = (32'(cnt_inc) < high);
                tick_d    = wrap;
            end
        end else if (apply) begin
            // Park at the last count of the new ratio so resuming wraps immediately.
            cnt_d = shadow - WIDTH'(1);
        end
    end

    // Counter and output flops; reset parks the counter so the first enabled edge wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= WIDTH'(DEFAULT_DIV - 1);
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: expected outputs queued per driven cycle, checked after each edge.
module tb_clk_div_prog;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] div_in;
    logic       load;
    logic       load_ack;
    logic       pending;
    logic       clk_out;
    logic       tick;

    typedef struct {
        logic  t;
        logic  c;
        logic  a;
        logic  p;
        string tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   passes;
    int   step_no;

    clk_div_prog #(.WIDTH(8), .DEFAULT_DIV(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .div_in   (div_in),
        .load     (load),
        .load_ack (load_ack),
        .pending  (pending),
        .clk_out  (clk_out),
        .tick     (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    // Drive one cycle of stimulus and queue what the following edge must produce.
    task automatic step(input logic e, input logic ld, input logic [7:0] d,
                        input logic xt, input logic xc, input logic xa, input logic xp,
                        input string phase);
        exp_t x;
        @(negedge clk);
        en     = e;
        load   = ld;
        div_in = d;
        step_no++;
        x.t = xt; x.c = xc; x.a = xa; x.p = xp;
        x.tag = $sformatf("%s#%0d", phase, step_no);
        exp_q.push_back(x);
    endtask

    // Scoreboard: compare the oldest queued expectation just after each edge.
    always begin
        exp_t x;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            check({x.tag, ".tick"},     tick,     x.t);
            check({x.tag, ".clk_out"},  clk_out,  x.c);
            check({x.tag, ".load_ack"}, load_ack, x.a);
            check({x.tag, ".pending"},  pending,  x.p);
            $display("cycle %s: tick=%b clk_out=%b load_ack=%b pending=%b", x.tag, tick, clk_out, load_ack, pending);
        end
    end

    task automatic drain();
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        check("drain_queue_empty", 1'b1, exp_q.size() == 0);
    endtask

    initial begin
        checks  = 0;
        passes  = 0;
        step_no = 0;
        rst     = 1'b0;
        en      = 1'b0;
        load    = 1'b0;
        div_in  = '0;
        #2;
        check("rst.clk_out",  clk_out,  1'b0);
        check("rst.tick",     tick,     1'b0);
        check("rst.load_ack", load_ack, 1'b0);
        check("rst.pending",  pending,  1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Default ratio 2: tick on odd edges, clk_out alternates starting high.
        for (int i = 0; i < 2; i++) begin
            step(1, 0, 0, 1, 1, 0, 0, "rst_div2");
            step(1, 0, 0, 0, 0, 0, 0, "rst_div2");
        end

        // Load 4 coincident with a wrap: old ratio kept for that wrap.
        step(1, 1, 4, 1, 1, 0, 1, "ld4_coinc");
        step(1, 0, 0, 0, 0, 0, 1, "ld4_coinc");
        step(1, 0, 0, 1, 1, 1, 0, "ld4_apply");
        step(1, 0, 0, 0, 1, 0, 0, "div4");
        step(1, 0, 0, 0, 0, 0, 0, "div4");
        step(1, 0, 0, 0, 0, 0, 0, "div4");
        step(1, 0, 0, 1, 1, 0, 0, "div4");
        step(1, 0, 0, 0, 1, 0, 0, "div4");

        // Load 5 mid-period at N=4: old period completes, then 3 high / 2 low.
        step(1, 1, 5, 0, 0, 0, 1, "ld5_mid");
        step(1, 0, 0, 0, 0, 0, 1, "ld5_mid");
        step(1, 0, 0, 1, 1, 1, 0, "ld5_apply");
        for (int i = 0; i < 2; i++) begin
            if (i != 0) step(1, 0, 0, 1, 1, 0, 0, "div5");
            step(1, 0, 0, 0, 1, 0, 0, "div5");
            step(1, 0, 0, 0, 1, 0, 0, "div5");
            step(1, 0, 0, 0, 0, 0, 0, "div5");
            step(1, 0, 0, 0, 0, 0, 0, "div5");
        end

        // Bypass with div_in=0, then div_in=1.
        step(1, 1, 0, 1, 1, 0, 1, "ld0_coinc");
        step(1, 0, 0, 0, 1, 0, 1, "ld0_wait");
        step(1, 0, 0, 0, 1, 0, 1, "ld0_wait");
        step(1, 0, 0, 0, 0, 0, 1, "ld0_wait");
        step(1, 0, 0, 0, 0, 0, 1, "ld0_wait");
        step(1, 0, 0, 1, 1, 1, 0, "ld0_apply");
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 1, 0, 0, "div0_bypass");
        step(1, 1, 1, 1, 1, 0, 1, "ld1");
        step(1, 0, 0, 1, 1, 1, 0, "ld1_apply");
        for (int i = 0; i < 2; i++) step(1, 0, 0, 1, 1, 0, 0, "div1_bypass");

        // Ratio 6, pause for 4 edges at cnt=2, then the remaining 3 cycles.
        step(1, 1, 6, 1, 1, 0, 1, "ld6");
        step(1, 0, 0, 1, 1, 1, 0, "ld6_apply");
        step(1, 0, 0, 0, 1, 0, 0, "div6");
        step(1, 0, 0, 0, 1, 0, 0, "div6");
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0, 0, "pause");
        step(1, 0, 0, 0, 0, 0, 0, "resume");
        step(1, 0, 0, 0, 0, 0, 0, "resume");
        step(1, 0, 0, 0, 0, 0, 0, "resume");
        step(1, 0, 0, 1, 1, 0, 0, "resume_wrap");

        // Second load while pending is refused; only ratio 3 takes effect.
        step(1, 1, 3, 0, 1, 0, 1, "ld3");
        step(1, 1, 7, 0, 1, 0, 1, "ld7_refused");
        step(1, 0, 0, 0, 0, 0, 1, "ld3_wait");
        step(1, 0, 0, 0, 0, 0, 1, "ld3_wait");
        step(1, 0, 0, 0, 0, 0, 1, "ld3_wait");
        step(1, 0, 0, 1, 1, 1, 0, "ld3_apply");
        step(1, 0, 0, 0, 1, 0, 0, "div3");
        step(1, 0, 0, 0, 0, 0, 0, "div3");
        step(1, 0, 0, 1, 1, 0, 0, "div3");

        // Load while paused applies on the next edge; first enabled edge ticks.
        step(0, 1, 4, 0, 1, 0, 1, "ld4_paused");
        step(0, 0, 0, 0, 1, 1, 0, "ld4_paused_apply");
        step(1, 0, 0, 1, 1, 0, 0, "div4_resume");
        step(1, 0, 0, 0, 1, 0, 0, "div4_resume");
        step(1, 0, 0, 0, 0, 0, 0, "div4_resume");
        step(1, 0, 0, 0, 0, 0, 0, "div4_resume");
        step(1, 0, 0, 1, 1, 0, 0, "div4_resume");

        // Reset with a request pending: outputs clear at once, no ack afterwards.
        step(1, 1, 9, 0, 1, 0, 1, "ld9_pending");
        drain();
        rst = 1'b0;
        #1;
        check("midrst.clk_out",  clk_out,  1'b0);
        check("midrst.tick",     tick,     1'b0);
        check("midrst.load_ack", load_ack, 1'b0);
        check("midrst.pending",  pending,  1'b0);
        @(negedge clk);
        en   = 1'b0;
        load = 1'b0;
        rst  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 1, 1, 0, 0, "post_rst_div2");
            step(1, 0, 0, 0, 0, 0, 0, "post_rst_div2");
        end
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
